// File: rtl/axi_arb_pkg.sv
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared types and payload layout for the 2:1 AXI arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

    localparam int AR_PLD_W   = 61;   // {id,len,size,burst,addr}
    localparam int W_PLD_W    = 145;  // {wlast,wstrb,wdata}
    localparam int R_PLD_W    = 139;  // {rlast,rresp,rid,rdata}
    localparam int B_PLD_W    = 10;   // {bresp,bid}

    localparam int AR_ID_LSB  = 53;
    localparam int W_LAST_BIT = 144;
    localparam int R_ID_LSB   = 128;
    localparam int R_LAST_BIT = 138;
    localparam int B_ID_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_arb_rr2.sv
// ============================================================================
// Module      : axi_arb_rr2
// Description : Two-request round-robin picker; rr_ptr breaks ties.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_arb_rr2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       winner
);

    // A lone requester wins outright; rr_ptr only matters on a tie.
    assign winner = (req == 2'b11) ? rr_ptr : req[1];

endmodule

`default_nettype wire

// File: rtl/axi_arb2to1_128.sv
// ============================================================================
// Module      : axi_arb2to1_128
// Description : Two-master to one-slave AXI arbiter, whole-burst round robin.
//               Optional macro AXI_ARB_ID_TAG_EN: tag ID MSB with the grant.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_arb2to1_128
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 128,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 8
) (
    input  logic                  pll_core_cpuclk,
    input  logic                  pad_cpu_rst,
    input  logic [1:0]            m_arvalid,
    output logic [1:0]            m_arready,
    input  logic [2*AR_PLD_W-1:0] m_ar_pld,
    input  logic [1:0]            m_awvalid,
    output logic [1:0]            m_awready,
    input  logic [2*AR_PLD_W-1:0] m_aw_pld,
    input  logic [1:0]            m_wvalid,
    output logic [1:0]            m_wready,
    input  logic [2*W_PLD_W-1:0]  m_w_pld,
    output logic [1:0]            m_rvalid,
    input  logic [1:0]            m_rready,
    output logic [R_PLD_W-1:0]    m_r_pld,
    output logic [1:0]            m_bvalid,
    input  logic [1:0]            m_bready,
    output logic [B_PLD_W-1:0]    m_b_pld,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [AR_PLD_W-1:0]   s_ar_pld,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [AR_PLD_W-1:0]   s_aw_pld,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [W_PLD_W-1:0]    s_w_pld,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [R_PLD_W-1:0]    s_r_pld,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [B_PLD_W-1:0]    s_b_pld
);

    localparam int c_AR_ID_LSB = ADDR_W + 2 + 3 + LEN_W;
    localparam int c_W_LAST    = DATA_W + DATA_W / 8;
    localparam int c_R_ID_LSB  = DATA_W;
    localparam int c_R_LAST    = DATA_W + ID_W + 2;

    arb_state_t            r_state;
    logic                  r_grant;
    logic                  r_rr_ptr;
    logic [1:0]            w_req;
    logic                  w_winner;
    logic [AR_PLD_W-1:0]   w_ar_sel;
    logic [AR_PLD_W-1:0]   w_aw_sel;
    logic [ID_W-1:0]       w_ar_id;
    logic [ID_W-1:0]       w_aw_id;
    logic [ID_W-1:0]       w_r_id;
    logic [ID_W-1:0]       w_b_id;
    logic                  w_r_route;
    logic                  w_b_route;

    assign w_req = m_arvalid | m_awvalid;

    axi_arb_rr2 u_rr2 (
        .req    (w_req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner)
    );

    assign w_ar_sel = r_grant ? m_ar_pld[2*AR_PLD_W-1 -: AR_PLD_W] : m_ar_pld[AR_PLD_W-1:0];
    assign w_aw_sel = r_grant ? m_aw_pld[2*AR_PLD_W-1 -: AR_PLD_W] : m_aw_pld[AR_PLD_W-1:0];
    assign s_w_pld  = r_grant ? m_w_pld[2*W_PLD_W-1 -: W_PLD_W]    : m_w_pld[W_PLD_W-1:0];

`ifdef AXI_ARB_ID_TAG_EN
    // The ID MSB carries the master index out and steers responses back.
    assign w_ar_id   = {r_grant, w_ar_sel[c_AR_ID_LSB +: ID_W-1]};
    assign w_aw_id   = {r_grant, w_aw_sel[c_AR_ID_LSB +: ID_W-1]};
    assign w_r_route = s_r_pld[c_R_ID_LSB + ID_W - 1];
    assign w_b_route = s_b_pld[ID_W-1];
    assign w_r_id    = {1'b0, s_r_pld[c_R_ID_LSB +: ID_W-1]};
    assign w_b_id    = {1'b0, s_b_pld[ID_W-2:0]};
`else
    assign w_ar_id   = w_ar_sel[c_AR_ID_LSB +: ID_W];
    assign w_aw_id   = w_aw_sel[c_AR_ID_LSB +: ID_W];
    assign w_r_route = r_grant;
    assign w_b_route = r_grant;
    assign w_r_id    = s_r_pld[c_R_ID_LSB +: ID_W];
    assign w_b_id    = s_b_pld[ID_W-1:0];
`endif

    assign s_ar_pld = {w_ar_id, w_ar_sel[c_AR_ID_LSB-1:0]};
    assign s_aw_pld = {w_aw_id, w_aw_sel[c_AR_ID_LSB-1:0]};
    assign m_r_pld  = {s_r_pld[R_PLD_W-1:c_R_ID_LSB+ID_W], w_r_id, s_r_pld[c_R_ID_LSB-1:0]};
    assign m_b_pld  = {s_b_pld[B_PLD_W-1:ID_W], w_b_id};

    // Handshakes are opened only for the owner; IDLE is a deliberate bubble.
    always_comb begin
        m_arready = 2'b00;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_rvalid  = 2'b00;
        m_bvalid  = 2'b00;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_rready  = 1'b0;
        s_bready  = 1'b0;
        case (r_state)
            ST_RD_ADDR: begin
                s_arvalid          = m_arvalid[r_grant];
                m_arready[r_grant] = s_arready;
            end
            ST_RD_DATA: begin
                m_rvalid[w_r_route] = s_rvalid;
                s_rready            = m_rready[w_r_route];
            end
            ST_WR_ADDR: begin
                s_awvalid          = m_awvalid[r_grant];
                m_awready[r_grant] = s_awready;
            end
            ST_WR_DATA: begin
                s_wvalid          = m_wvalid[r_grant];
                m_wready[r_grant] = s_wready;
            end
            ST_WR_RESP: begin
                m_bvalid[w_b_route] = s_bvalid;
                s_bready            = m_bready[w_b_route];
            end
            default: ;
        endcase
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_winner;
                        r_state <= m_arvalid[w_winner] ? ST_RD_ADDR : ST_WR_ADDR;
                    end
                end
                ST_RD_ADDR: if (s_arvalid && s_arready) r_state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    if (s_rvalid && s_rready && s_r_pld[c_R_LAST]) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= ~r_grant;
                    end
                end
                ST_WR_ADDR: if (s_awvalid && s_awready) r_state <= ST_WR_DATA;
                ST_WR_DATA: if (s_wvalid && s_wready && s_w_pld[c_W_LAST]) r_state <= ST_WR_RESP;
                ST_WR_RESP: begin
                    if (s_bvalid && s_bready) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= ~r_grant;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A granted master must hold its address valid until the slave accepts.
    a_ar_hold: assert property (@(posedge pll_core_cpuclk) disable iff (pad_cpu_rst)
        (r_state == ST_RD_ADDR) |-> m_arvalid[r_grant]);
    a_aw_hold: assert property (@(posedge pll_core_cpuclk) disable iff (pad_cpu_rst)
        (r_state == ST_WR_ADDR) |-> m_awvalid[r_grant]);
`endif

endmodule

`default_nettype wire
